unstriping_4: RTL and testbench
===============================

UNSTRIPING_4 -- requirements
Module: unstriping_4

Interface
REQ-001 The block SHALL have a single clock domain and SHALL use an asynchronous, active-low reset.
REQ-002 Port clk_1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low; 0 clears all state immediately, independent of clk_1.
REQ-004 Port dataIn, input, 8 bits: serial byte stream.
REQ-005 Port validIn, input, 1 bit: dataIn carries a byte this cycle.
REQ-006 Port readyOut, output, 1 bit: the block can accept a byte this cycle.
REQ-007 Port selector, input, 1 bit: lane mode; 0 = 4 lanes, 1 = 2 lanes.
REQ-008 Ports dataOut0, dataOut1, dataOut2, dataOut3, output, 8 bits each: lane bytes of the presented group.
REQ-009 Ports validOut0, validOut1, validOut2, validOut3, output, 1 bit each: per-lane valid of the presented group.
REQ-010 Port readyIn, input, 1 bit: downstream accepts the presented group.
REQ-011 Port groupCount, output, 8 bits: count of groups delivered downstream.

Function
REQ-012 A byte SHALL be accepted on a rising edge where validIn=1 and readyOut=1; no other condition accepts a byte.
REQ-013 readyOut SHALL be combinational and equal to (no group presented) OR readyIn.
REQ-014 The lane pointer ptr[1:0] SHALL start at 0; each accepted byte SHALL be written to staging lane ptr, and ptr SHALL then increment.
REQ-015 ptr SHALL wrap to 0 after lane 3 in 4-lane mode and after lane 1 in 2-lane mode.
REQ-016 The lane mode SHALL be registered from selector only on an accepted byte with ptr=0.
REQ-017 A selector change in the middle of a group SHALL have no effect until the next group starts.
REQ-018 Accepting the last byte of a group SHALL load the output registers on that same edge, taking earlier lanes from staging and the last lane from dataIn.
REQ-019 After REQ-018, validOutN SHALL be 1 for the group's lanes from the next cycle; this is 1-cycle latency from the last byte's edge.
REQ-020 In 2-lane mode, dataOut2 and dataOut3 SHALL be 00 and validOut2 and validOut3 SHALL be 0.
REQ-021 A presented group SHALL hold dataOutN and validOutN stable until a rising edge with readyIn=1; that edge is the transfer.
REQ-022 After a transfer, validOutN SHALL clear unless a new group completes on the same edge; in that case the new group SHALL be loaded with no bubble.
REQ-023 groupCount SHALL increment by 1 on each transfer and SHALL wrap from FF to 00.
REQ-024 While validIn=0, ptr and any partial group SHALL hold indefinitely; there is no timeout.
REQ-025 While a group is presented, readyIn=0 and validIn=1, no byte SHALL be accepted; the source holds dataIn.
REQ-026 readyIn while nothing is presented SHALL be ignored, and groupCount SHALL NOT change.

Reset
REQ-027 While reset=0, the block SHALL hold dataOut0-3=00, validOut0-3=0, groupCount=00, ptr=0, staging=00 and mode=4-lane.
REQ-028 While reset=0, readyOut SHALL be 1.
REQ-029 A reset in the middle of a group SHALL discard both the partial group and any presented group.
REQ-030 The first accepted byte after reset is released SHALL be treated as lane 0.

Verification
REQ-031 The bench SHALL cover: reset=0 with random inputs -> all outputs at reset values, readyOut=1.
REQ-032 The bench SHALL cover: selector=0, readyIn=1, bytes FF,15,37,51 on 4 consecutive edges -> next cycle dataOut0-3=FF,15,37,51, validOut0-3=1111; one cycle later validOut=0000, groupCount=01.
REQ-033 The bench SHALL cover: selector=1, bytes AA,55 -> dataOut0=AA, dataOut1=55, validOut=0011, dataOut2/3=00.
REQ-034 The bench SHALL cover: readyIn=0 with a group presented and 2 more bytes offered -> readyOut=0 and outputs stable; readyIn=1 -> transfer, and the held bytes are then accepted in order.
REQ-035 The bench SHALL cover: selector toggled 0->1 after byte 2 of a 4-lane group -> the group still completes as 4 lanes, and the next group is 2-lane.
REQ-036 The bench SHALL cover: 256 four-lane groups transferred -> groupCount=00; then reset asserted after 2 bytes of a group -> the next 4 bytes form a fresh group starting at lane 0.

Source files
------------

// File: rtl/unstriping_4.sv
// Byte-serial to lane-parallel unstriper: gathers 4 (or 2) consecutive bytes
// into one group and presents them with valid/ready handshaking downstream.

module unstripingLane (
  input  logic       clk_1,
  input  logic       reset,
  input  logic [7:0] dataIn,
  input  logic       hit,        // accepted byte targets this lane
  input  logic       load,       // group completes on this edge
  input  logic       inGroup,    // lane belongs to the completing group
  input  logic       isLast,     // lane is the group's final lane
  input  logic       transfer,
  output logic [7:0] dataOut,
  output logic       validOut
);
  logic [7:0] stage;

  always_ff @(posedge clk_1 or negedge reset) begin
    if (!reset) begin
      stage    <= '0;
      dataOut  <= '0;
      validOut <= 1'b0;
    end else begin
      if (hit) stage <= dataIn;
      if (load) begin
        validOut <= inGroup;
        // last lane bypasses staging so the group loads on the final byte's edge
        dataOut  <= !inGroup ? 8'h00 : (isLast ? dataIn : stage);
      end else if (transfer) begin
        validOut <= 1'b0;
      end
    end
  end
endmodule

module unstriping_4 (
  input  logic       clk_1,
  input  logic       reset,
  input  logic [7:0] dataIn,
  input  logic       validIn,
  output logic       readyOut,
  input  logic       selector,
  output logic [7:0] dataOut0,
  output logic [7:0] dataOut1,
  output logic [7:0] dataOut2,
  output logic [7:0] dataOut3,
  output logic       validOut0,
  output logic       validOut1,
  output logic       validOut2,
  output logic       validOut3,
  input  logic       readyIn,
  output logic [7:0] groupCount
);
  localparam int NUM_LANES = 4;

  logic                      mode;     // 1 = 2-lane
  logic [1:0]                ptr;
  logic                      effMode;
  logic [1:0]                lastPtr;
  logic                      presented;
  logic                      accept;
  logic                      groupDone;
  logic                      transfer;
  logic [NUM_LANES-1:0][7:0] laneData;
  logic [NUM_LANES-1:0]      laneValid;

  // mode is sampled from selector only at the first byte of a group
  assign effMode   = (ptr == 2'd0) ? selector : mode;
  assign lastPtr   = effMode ? 2'd1 : 2'd3;
  assign presented = |laneValid;
  assign readyOut  = !presented || readyIn;
  assign accept    = validIn && readyOut;
  assign groupDone = accept && (ptr == lastPtr);
  assign transfer  = presented && readyIn;

  always_ff @(posedge clk_1 or negedge reset) begin
    if (!reset) begin
      mode       <= 1'b0;
      ptr        <= 2'd0;
      groupCount <= 8'h00;
    end else begin
      if (accept) begin
        if (ptr == 2'd0) mode <= selector;
        ptr <= groupDone ? 2'd0 : ptr + 2'd1;
      end
      if (transfer) groupCount <= groupCount + 8'h01;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    unstripingLane uLane (
      .clk_1    (clk_1),
      .reset    (reset),
      .dataIn   (dataIn),
      .hit      (accept && (ptr == 2'(i))),
      .load     (groupDone),
      .inGroup  (2'(i) <= lastPtr),
      .isLast   (2'(i) == lastPtr),
      .transfer (transfer),
      .dataOut  (laneData[i]),
      .validOut (laneValid[i])
    );
  end

  assign dataOut0  = laneData[0];
  assign dataOut1  = laneData[1];
  assign dataOut2  = laneData[2];
  assign dataOut3  = laneData[3];
  assign validOut0 = laneValid[0];
  assign validOut1 = laneValid[1];
  assign validOut2 = laneValid[2];
  assign validOut3 = laneValid[3];
endmodule

// File: tb/tb_unstriping_4.sv
// Scoreboard bench for unstriping_4: stimulus pushes expected groups, a monitor
// pops and compares on every downstream transfer.

module tb_unstriping_4;
  logic       clk_1 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dataIn = '0;
  logic       validIn = 1'b0;
  logic       readyOut;
  logic       selector = 1'b0;
  logic [7:0] dataOut0, dataOut1, dataOut2, dataOut3;
  logic       validOut0, validOut1, validOut2, validOut3;
  logic       readyIn = 1'b0;
  logic [7:0] groupCount;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  vld;
  } grp_t;

  grp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] expCount = '0;
  wire [31:0] dOut = {dataOut3, dataOut2, dataOut1, dataOut0};
  wire [3:0]  vOut = {validOut3, validOut2, validOut1, validOut0};

  unstriping_4 dut (
    .clk_1(clk_1), .reset(reset), .dataIn(dataIn), .validIn(validIn),
    .readyOut(readyOut), .selector(selector),
    .dataOut0(dataOut0), .dataOut1(dataOut1), .dataOut2(dataOut2), .dataOut3(dataOut3),
    .validOut0(validOut0), .validOut1(validOut1), .validOut2(validOut2), .validOut3(validOut3),
    .readyIn(readyIn), .groupCount(groupCount)
  );

  always #5 clk_1 = ~clk_1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
  task automatic sendByte(input logic [7:0] b, input logic sel);
    int   n;
    logic acc;
    dataIn = b; validIn = 1'b1; selector = sel; n = 0;
    do begin
      @(negedge clk_1); acc = readyOut;
      @(posedge clk_1); #1; n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL sendTimeout: byte %h never accepted", b);
    end
  endtask

  task automatic sendGroup4(input logic [7:0] d0, d1, d2, d3, input logic s);
    sb.push_back('{data: {d3, d2, d1, d0}, vld: 4'hF});
    sendByte(d0, s); sendByte(d1, s); sendByte(d2, s); sendByte(d3, s);
  endtask

  task automatic doReset();
    reset = 1'b0;
    repeat (2) @(posedge clk_1);
    #1;
    sb.delete();
    chk("rstCount", 32'(groupCount), 32'h0);
    chk("rstValid", 32'(vOut), 32'h0);
    chk("rstReady", 32'(readyOut), 32'h1);
    reset = 1'b1;
  endtask

  // monitor: every transfer edge pops one expected group
  initial begin
    grp_t g;
    forever begin
      @(negedge clk_1);
      if (!reset) expCount = '0;
      else if (vOut != 4'h0 && readyIn) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpectedGroup: got %h valid %b expected none", dOut, vOut);
        end else begin
          g = sb.pop_front();
          chk("grpData", dOut, g.data);
          chk("grpValid", 32'(vOut), 32'(g.vld));
          chk("grpCount", 32'(groupCount), 32'(expCount));
          expCount++;
        end
      end
    end
  end

  initial begin
    // held in reset with random inputs
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_1); #1;
      dataIn = 8'($urandom); validIn = 1'($urandom); selector = 1'($urandom); readyIn = 1'($urandom);
      @(negedge clk_1);
      chk("rstData", dOut, 32'h0);
      chk("rstValid", 32'(vOut), 32'h0);
      chk("rstCount", 32'(groupCount), 32'h0);
      chk("rstReady", 32'(readyOut), 32'h1);
    end
    @(posedge clk_1); #1;
    validIn = 1'b0; readyIn = 1'b1; reset = 1'b1;

    // 4-lane group, 1-cycle latency then transfer
    sendGroup4(8'hFF, 8'h15, 8'h37, 8'h51, 1'b0);
    validIn = 1'b0;
    chk("g4Data", dOut, 32'h513715FF);
    chk("g4Valid", 32'(vOut), 32'hF);
    @(posedge clk_1); #1;
    chk("g4Clear", 32'(vOut), 32'h0);
    chk("g4Count", 32'(groupCount), 32'h1);

    // 2-lane group
    sb.push_back('{data: 32'h000055AA, vld: 4'h3});
    sendByte(8'hAA, 1'b1); sendByte(8'h55, 1'b1);
    validIn = 1'b0;
    chk("g2Data", dOut, 32'h000055AA);
    chk("g2Valid", 32'(vOut), 32'h3);

    // back-pressure: group held, further bytes stalled
    @(posedge clk_1); #1;
    readyIn = 1'b0;
    sendGroup4(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    dataIn = 8'h05; validIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_1);
      chk("stallReady", 32'(readyOut), 32'h0);
      chk("stallData", dOut, 32'h04030201);
      chk("stallValid", 32'(vOut), 32'hF);
    end
    @(posedge clk_1); #1;
    readyIn = 1'b1;
    sendGroup4(8'h05, 8'h06, 8'h07, 8'h08, 1'b0);

    // selector change mid-group takes effect at the next group
    sendByte(8'h10, 1'b0); sendByte(8'h11, 1'b0);
    sb.push_back('{data: 32'h13121110, vld: 4'hF});
    sendByte(8'h12, 1'b1); sendByte(8'h13, 1'b1);
    chk("selHoldValid", 32'(vOut), 32'hF);
    sb.push_back('{data: 32'h00002120, vld: 4'h3});
    sendByte(8'h20, 1'b1); sendByte(8'h21, 1'b1);
    validIn = 1'b0;
    chk("selNextValid", 32'(vOut), 32'h3);
    @(posedge clk_1); #1;

    // 256 groups wrap the counter
    doReset();
    for (int i = 0; i < 256; i++)
      sendGroup4(8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i + 1), 1'b0);
    validIn = 1'b0;
    @(posedge clk_1); #1;
    chk("wrapCount", 32'(groupCount), 32'h0);
    chk("wrapValid", 32'(vOut), 32'h0);

    // reset mid-group discards the partial bytes
    sendByte(8'hE0, 1'b0); sendByte(8'hE1, 1'b0);
    validIn = 1'b0;
    doReset();
    sendGroup4(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b0);
    validIn = 1'b0;
    chk("freshData", dOut, 32'hC3C2C1C0);
    chk("freshValid", 32'(vOut), 32'hF);
    @(posedge clk_1); #1;
    chk("freshCount", 32'(groupCount), 32'h1);

    repeat (3) @(posedge clk_1);
    #1;
    chk("sbDrained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
